// File: rtl/regfile_dump_reader.sv
// Debug readback engine: walks register-file read port R0..R7 and streams each word with its index.
// Define REGFILE_DUMP_READER_CHECKSUM_EN to append an XOR checksum beat (out_idx=8) after R7.
module regfile_dump_reader #(
  parameter int NREG = 8,
  parameter int W    = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic         abort,
  output logic [2:0]   rd_sel,
  input  logic [W-1:0] rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_idx,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
`ifdef REGFILE_DUMP_READER_CHECKSUM_EN
  localparam logic [2:0] CSUM = 3'd3;
`endif
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [2:0] LAST = 3'(NREG - 1);

  logic [2:0] state;
  logic [2:0] idx;
`ifdef REGFILE_DUMP_READER_CHECKSUM_EN
  logic [W-1:0] acc;
`endif

  // idx is itself the registered read select; it is forced to 0 whenever the machine idles.
  assign rd_sel = idx;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
`ifdef REGFILE_DUMP_READER_CHECKSUM_EN
      acc       <= '0;
`endif
    end else if (abort && state != IDLE) begin
      // abort wins over a handshake completing in the same cycle
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= READ;
`ifdef REGFILE_DUMP_READER_CHECKSUM_EN
            acc   <= '0;
`endif
          end
        end
        READ: begin
          out_data  <= rd_data;
          out_idx   <= {1'b0, idx};
          out_valid <= 1'b1;
          state     <= SEND;
`ifdef REGFILE_DUMP_READER_CHECKSUM_EN
          acc       <= acc ^ rd_data;
`endif
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx != LAST) begin
              idx   <= idx + 3'd1;
              state <= READ;
            end else begin
`ifdef REGFILE_DUMP_READER_CHECKSUM_EN
              // acc already holds the last word, captured in R7's READ
              out_data  <= acc;
              out_idx   <= 4'd8;
              out_valid <= 1'b1;
              state     <= CSUM;
`else
              state     <= DONE;
`endif
            end
          end
        end
`ifdef REGFILE_DUMP_READER_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          idx   <= '0;
          state <= IDLE;
        end
        default: begin
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table of dump scenarios checked through a beat scoreboard,
// plus hand sequences for reset mid-dump, abort/ignored start and a write during the dump.
module tb_regfile_dump_reader;

`ifdef REGFILE_DUMP_READER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, start, abort, out_ready;
  logic [2:0]  rd_sel;
  logic [15:0] rd_data;
  logic        out_valid, busy, done;
  logic [3:0]  out_idx;
  logic [15:0] out_data;

  logic [15:0] rf [8];
  assign rd_data = rf[rd_sel];

  regfile_dump_reader #(.NREG(8), .W(16)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int nchk = 0, errs = 0;
  int cyc = 0, start_cyc = 0, done_cyc = -1, first_vld = -1;
  bit done_seen = 0;
  logic [19:0] q [$];

  always @(posedge Clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every presented beat must match the queue head; pop on handshake.
  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      if (out_valid === 1'b1) begin
        if (first_vld < 0) first_vld = cyc;
        if (q.size() == 0) chk("unexpected_beat", {12'h0, out_idx, out_data}, 32'hFFFF_FFFF);
        else begin
          chk("beat", {12'h0, out_idx, out_data}, {12'h0, q[0]});
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic push_expected(input logic [15:0] w [8]);
    logic [15:0] x = '0;
    for (int i = 0; i < 8; i++) begin
      q.push_back({4'(i), w[i]});
      x ^= w[i];
    end
    if (CS != 0) q.push_back({4'd8, x});
  endtask

  task automatic drive_start();
    @(posedge Clk); #1;
    start = 1'b1; start_cyc = cyc; done_seen = 0; done_cyc = -1; first_vld = -1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_beat(input logic [3:0] idx);
    bit hit = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge Clk); #1;
      if (out_valid && out_idx == idx) hit = 1;
    end
    if (!hit) chk("wait_beat_timeout", 32'(idx), 32'hFFFF);
  endtask

  task automatic finish_dump(input logic [3:0] stall_idx, input int stall_len, input int exp_lat);
    int stalled = 0;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      if (out_valid && out_idx == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else out_ready = 1'b1;
      @(posedge Clk); #1;
    end
    out_ready = 1'b1;
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("done_latency", 32'(done_cyc - start_cyc), 32'(exp_lat));
    chk("first_valid_latency", 32'(first_vld - start_cyc), 32'd2);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    q.delete();
  endtask

  typedef struct {
    int         pat;        // 0: 16'h1000+i, 1: one-hot, 2: random
    logic [3:0] stall_idx;  // 15 = no stall
    int         stall_len;
    int         exp_lat;
  } vec_t;

  vec_t vecs [4];
  logic [15:0] w [8];

  initial begin
    vecs[0] = '{0, 4'd15, 0, 17 + CS};
    vecs[1] = '{0, 4'd2,  5, 22 + CS};
    vecs[2] = '{2, 4'd7,  3, 20 + CS};
    vecs[3] = '{1, 4'd15, 0, 17 + CS};

    Reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
    #2 Reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_sel", 32'(rd_sel), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_data", 32'(out_data), 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;

    // Reset mid-dump, during the SEND of R3, away from any clock edge
    for (int i = 0; i < 8; i++) w[i] = 16'h1000 + 16'(i);
    push_expected(w);
    drive_start();
    wait_beat(4'd3);
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rd_sel", 32'(rd_sel), 0);
    chk("mid_rst_out_data", 32'(out_data), 0);
    q.delete();
    @(posedge Clk); #1 Reset = 1'b1;

    // Table: the first entry also proves the restart from R0 after the reset
    foreach (vecs[v]) begin
      for (int i = 0; i < 8; i++) begin
        case (vecs[v].pat)
          0: w[i] = 16'h1000 + 16'(i);
          1: w[i] = 16'h0001 << i;
          default: w[i] = 16'($urandom);
        endcase
        rf[i] = w[i];
      end
      push_expected(w);
      drive_start();
      finish_dump(vecs[v].stall_idx, vecs[v].stall_len, vecs[v].exp_lat);
    end

    // Start during R5 SEND is ignored; abort (with a simultaneous handshake) returns to IDLE
    for (int i = 0; i < 8; i++) begin w[i] = 16'h1000 + 16'(i); rf[i] = w[i]; end
    push_expected(w);
    drive_start();
    wait_beat(4'd5);
    out_ready = 1'b0; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    chk("ign_start_idx", 32'(out_idx), 5);
    chk("ign_start_valid", 32'(out_valid), 1);
    chk("ign_start_busy", 32'(busy), 1);
    chk("ign_start_data", 32'(out_data), 32'h1005);
    out_ready = 1'b1; abort = 1'b1;
    @(posedge Clk); #1;
    abort = 1'b0; out_ready = 1'b1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_rd_sel", 32'(rd_sel), 0);
    q.delete();
    done_seen = 0;
    repeat (4) @(posedge Clk);
    #1 chk("abort_no_done", 32'(done_seen), 0);

    // CPU writes R6 while R1 is being sent; R6 beat must carry the new value
    for (int i = 0; i < 8; i++) begin w[i] = 16'h1000 + 16'(i); rf[i] = w[i]; end
    w[6] = 16'hBEEF;
    push_expected(w);
    drive_start();
    wait_beat(4'd1);
    rf[6] = 16'hBEEF;
    finish_dump(4'd15, 0, 17 + CS);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
